aes_key_expander: RTL and testbench
===================================

# aes_key_expander

Sequential AES-128 key-expansion controller. It accepts a 128-bit cipher key and computes round keys 1–10 at one round per clock, using the team's combinational `sub_byte` S-box for the g-function. Each round key is streamed out as it is produced and also stored in an 11-entry round-key buffer. The round datapath reads that buffer by index. The block sits between key load and the round datapath, and owns round numbering and the Rcon sequence.

## Interface
Parameters: none. AES-128 only; the block is fixed at 11 round keys.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — request expansion of `key_in`; sampled only while `busy`=0.
- `key_in`  in  128  — cipher key; word w0 = `[127:96]`, w3 = `[31:0]`; sampled on the accepting edge only.
- `busy`  out  1  — expansion in progress.
- `done`  out  1  — one-cycle pulse; round key 10 is stored.
- `keys_valid`  out  1  — all 11 buffer entries hold the current key's schedule.
- `rk_valid`  out  1  — `rk_out` and `rk_round` are valid this cycle.
- `rk_round`  out  4  — index 0–10 of `rk_out`.
- `rk_out`  out  128  — streamed round key.
- `rd_addr`  in  4  — buffer read index.
- `rd_key`  out  128  — combinational read of buffer entry `rd_addr`; returns 0 for `rd_addr` > 10.

## Operation
- States:
  - IDLE (`busy`=0).
  - EXPAND (`busy`=1).
  - A 4-bit round counter `rc`.
- IDLE with `start`=1 on edge T:
  - buffer[0] ← `key_in`; working key ← `key_in`.
  - `rk_out` ← `key_in`, `rk_round` ← 0, `rk_valid` ← 1.
  - `keys_valid` ← 0, `rc` ← 1, state → EXPAND.
- EXPAND, each edge:
  - Compute the next key from the working key using round `rc`:
    - g = SubWord(RotWord(w3)) ^ {Rcon[rc], 24'h0}, where RotWord(w3) = {w3[23:0], w3[31:24]}.
    - w4 = w0^g; w5 = w1^w4; w6 = w2^w5; w7 = w3^w6; next key = {w4, w5, w6, w7}.
  - buffer[rc] ← next key; working key ← next key.
  - `rk_out` ← next key, `rk_round` ← `rc`, `rk_valid` ← 1.
  - If `rc`=10: state → IDLE, `done` ← 1, `keys_valid` ← 1. Otherwise `rc` ← `rc`+1.
- Rcon[1..10]: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. Rcon is selected from the registered `rc`, never from a latch.
- `start` while `busy`=1: ignored; `key_in` is not sampled.
- `start` in the cycle where `done`=1: accepted, because the state is already IDLE. This clears `keys_valid` and begins a new schedule.
- Buffer writes occur only as described above. The buffer keeps its contents across new starts until each entry is overwritten.
- `rd_addr` reads during EXPAND return the current buffer contents, which may be a mix of old and new keys. Consumers must gate on `keys_valid`.
- Outside the cycles listed above, `rk_valid` ← 0 and `done` ← 0. `rk_out`/`rk_round` hold their last values.

## Timing
- Reset (`rst`=1 on an edge), all of the following hold the cycle after:
  - state IDLE, `rc`=0, `busy`=0.
  - `done`=0, `keys_valid`=0, `rk_valid`=0.
  - `rk_round`=0, `rk_out`=0.
  - All 11 buffer entries = 0, so `rd_key`=0.
- Reset mid-EXPAND aborts immediately: no `done` and no further writes.
- `rst` has priority over `start`.
- `busy` is high from the cycle after T through the cycle ending at edge T+10. It is low in the `done` cycle.
- `rk_valid` is high for 11 consecutive cycles, after edges T … T+10, with `rk_round` = 0 … 10.
- `done` and `keys_valid` rise after edge T+10, in the same cycle as `rk_round`=10.
- Latency from `start` to `done` = 11 cycles. Back-to-back expansions have an 11-cycle period.
- `rd_key` has zero-cycle latency from `rd_addr` and the buffer.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, `start` for 1 cycle:
  - `rk_round`=1 gives a0fafe1788542cb123a339392a6c7605.
  - `rk_round`=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` and `keys_valid` rise 11 cycles after start; `busy` is high for 10 cycles.
- Buffer readback after `done`:
  - `rd_addr` 0…10 matches the streamed keys.
  - `rd_addr`=1 gives a0fafe17…7605.
  - `rd_addr`=11 and 15 give 0.
- Key 000…0: round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- `start` pulsed with a different `key_in` at cycles T+3 and T+7 during EXPAND: ignored, and the schedule matches the original key.
- `start` held high through the `done` cycle:
  - A second expansion begins immediately; `keys_valid` falls the next cycle.
  - The old round-10 entry persists until it is rewritten at the new T+10.
- `rst` asserted at T+5: `busy`, `rk_valid` and `keys_valid` are 0 and all reads are 0 the next cycle. No `done` appears. A fresh start then completes normally.

Source files
------------

// File: rtl/aes_key_expander.sv
// AES-128 key-schedule controller: expands one round key per clock, streams each
// key out and keeps all eleven in a buffer that the round datapath reads by index.
module aes_key_expander (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] rk_out,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_key
);

    // state  | meaning
    // IDLE   | waiting for start; buffer holds the last (possibly partial) schedule
    // EXPAND | producing round key rc this cycle, rc = 1..10
    typedef enum logic {IDLE, EXPAND} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t       state;
    logic [3:0]   rc;
    logic [127:0] work;
    logic [127:0] next_key;
    logic [127:0] buffer [0:10];
    logic [31:0]  rot, sub, g, w4, w5, w6, w7;

    // Entry 0 sits in the top byte of SBOX, so byte b starts at bit (255-b)*8 = {~b, 3'b0}.
    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        rot = {work[23:0], work[31:24]};
        sub = {sub_byte(rot[31:24]), sub_byte(rot[23:16]),
               sub_byte(rot[15:8]),  sub_byte(rot[7:0])};
        g   = sub ^ {rcon(rc), 24'h000000};
        w4  = work[127:96] ^ g;
        w5  = work[95:64]  ^ w4;
        w6  = work[63:32]  ^ w5;
        w7  = work[31:0]   ^ w6;
        next_key = {w4, w5, w6, w7};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rc         <= 4'd0;
            work       <= '0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            rk_valid   <= 1'b0;
            rk_round   <= 4'd0;
            rk_out     <= '0;
            for (int i = 0; i < 11; i++) buffer[i] <= '0;
        end else begin
            done     <= 1'b0;
            rk_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        buffer[0]  <= key_in;
                        work       <= key_in;
                        rk_out     <= key_in;
                        rk_round   <= 4'd0;
                        rk_valid   <= 1'b1;
                        keys_valid <= 1'b0;
                        rc         <= 4'd1;
                        state      <= EXPAND;
                    end
                end
                EXPAND: begin
                    buffer[rc] <= next_key;
                    work       <= next_key;
                    rk_out     <= next_key;
                    rk_round   <= rc;
                    rk_valid   <= 1'b1;
                    if (rc == 4'd10) begin
                        state      <= IDLE;
                        done       <= 1'b1;
                        keys_valid <= 1'b1;
                    end else begin
                        rc <= rc + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state == EXPAND);
    assign rd_key = (rd_addr <= 4'd10) ? buffer[rd_addr] : '0;

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander: the stimulus queues expected round keys,
// a negedge monitor pops and compares whenever rk_valid is high.
module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [127:0] key_in;
    logic         busy, done, keys_valid, rk_valid;
    logic [3:0]   rk_round;
    logic [127:0] rk_out;
    logic [3:0]   rd_addr;
    logic [127:0] rd_key;

    aes_key_expander dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in),
        .busy(busy), .done(done), .keys_valid(keys_valid),
        .rk_valid(rk_valid), .rk_round(rk_round), .rk_out(rk_out),
        .rd_addr(rd_addr), .rd_key(rd_key)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
        bit           known;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    logic [127:0] fips [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] Z0  = 128'h0;
    localparam logic [127:0] Z1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Zero key: only rounds 0, 1 and 10 are tabled; other rounds check numbering only.
    function automatic exp_t zexp(input int r);
        exp_t e;
        e.rnd   = 4'(r);
        e.known = (r == 0 || r == 1 || r == 10);
        e.key   = (r == 0) ? Z0 : (r == 1) ? Z1 : (r == 10) ? Z10 : '0;
        return e;
    endfunction

    task automatic push_sched(input bit zero);
        exp_t e;
        for (int r = 0; r < 11; r++) begin
            if (zero) e = zexp(r);
            else begin
                e.rnd = 4'(r); e.key = fips[r]; e.known = 1'b1;
            end
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rk_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rk: round %0d key %h with empty scoreboard", rk_round, rk_out);
            end else begin
                mon_e = sb.pop_front();
                chk("rk_round", {124'h0, rk_round}, {124'h0, mon_e.rnd});
                if (mon_e.known) chk("rk_out", rk_out, mon_e.key);
            end
        end
    end

    task automatic run_key(input bit zero);
        int n, nb;
        bit seen;
        @(posedge clk); #1;
        key_in = zero ? Z0 : fips[0];
        start  = 1'b1;
        push_sched(zero);
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; nb = 0; seen = 0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("kv_low_after_start", {127'h0, keys_valid}, 128'd0);
            if (busy) nb++;
            if (done) seen = 1;
        end
        chk("done_latency", 128'(n), 128'd11);
        chk("busy_cycles", 128'(nb), 128'd10);
        chk("kv_at_done", {127'h0, keys_valid}, 128'd1);
        chk("busy_at_done", {127'h0, busy}, 128'd0);
    endtask

    task automatic readback(input bit zero);
        exp_t e;
        for (int a = 0; a < 11; a++) begin
            rd_addr = 4'(a); #1;
            if (zero) begin
                e = zexp(a);
                if (e.known) chk("readback", rd_key, e.key);
            end else chk("readback", rd_key, fips[a]);
        end
        rd_addr = 4'd11; #1; chk("read_addr11", rd_key, 128'd0);
        rd_addr = 4'd15; #1; chk("read_addr15", rd_key, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [127:0] acc;
        rst = 1'b1; start = 1'b0; key_in = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {127'h0, busy}, 128'd0);
        chk("rst_done", {127'h0, done}, 128'd0);
        chk("rst_kv", {127'h0, keys_valid}, 128'd0);
        chk("rst_rkv", {127'h0, rk_valid}, 128'd0);
        chk("rst_round", {124'h0, rk_round}, 128'd0);
        chk("rst_rk_out", rk_out, 128'd0);
        acc = '0;
        for (int a = 0; a < 16; a++) begin rd_addr = 4'(a); #1; acc |= rd_key; end
        chk("rst_buffer", acc, 128'd0);
        @(posedge clk); #1 rst = 1'b0;

        // FIPS-197 key, then the all-zero key
        run_key(1'b0);
        readback(1'b0);
        run_key(1'b1);
        readback(1'b1);

        // start pulses with another key during EXPAND are ignored
        @(posedge clk); #1;
        key_in = fips[0]; start = 1'b1; push_sched(1'b0);
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk); #1;
        key_in = Z0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (n < 10 && done !== 1'b1) begin @(negedge clk); n++; end
        chk("ignored_done_latency", 128'(n), 128'd4);
        rd_addr = 4'd10; #1;
        chk("ignored_r10", rd_key, fips[10]);

        // start held through the done cycle; key changes while busy
        @(posedge clk); #1;
        key_in = fips[0]; start = 1'b1; push_sched(1'b0);
        @(posedge clk); #1;
        key_in = Z0; push_sched(1'b1);
        n = 0;
        while (n < 20 && done !== 1'b1) begin @(negedge clk); n++; end
        chk("held_done_latency", 128'(n), 128'd11);
        chk("held_kv_at_done", {127'h0, keys_valid}, 128'd1);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("held_kv_fall", {127'h0, keys_valid}, 128'd0);
        chk("held_busy_restart", {127'h0, busy}, 128'd1);
        rd_addr = 4'd10; #1;
        chk("held_old_r10_kept", rd_key, fips[10]);
        @(negedge clk);
        rd_addr = 4'd1; #1;
        chk("held_new_r1", rd_key, Z1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rd_addr = 4'd10; #1;
        chk("held_old_r10_before_rewrite", rd_key, fips[10]);
        chk("held_no_early_done", {127'h0, done}, 128'd0);
        @(negedge clk);
        chk("held_new_r10", rd_key, Z10);
        chk("held_second_done", {127'h0, done}, 128'd1);

        // reset at T+5 aborts the schedule
        @(posedge clk); #1;
        key_in = fips[0]; start = 1'b1; push_sched(1'b0);
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {127'h0, busy}, 128'd0);
        chk("abort_rkv", {127'h0, rk_valid}, 128'd0);
        chk("abort_kv", {127'h0, keys_valid}, 128'd0);
        acc = '0;
        for (int a = 0; a < 16; a++) begin rd_addr = 4'(a); #1; acc |= rd_key; end
        chk("abort_buffer", acc, 128'd0);
        sb.delete();
        n = 0;
        repeat (15) begin @(negedge clk); if (done === 1'b1) n++; end
        chk("abort_no_done", 128'(n), 128'd0);
        run_key(1'b0);
        readback(1'b0);

        @(negedge clk);
        chk("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
